framebuffer_arbiter: RTL

- Shares the single-port 80x80 greyscale frame-buffer RAM (8-bit data, 13-bit address) between two requesters:
  - the VGA display fetch path (read-only, latency-critical);
  - an image-loader write port.
- Sits between the VGA monitor/sync logic and the RAM.
- Buffers loader writes in a small FIFO and drains them on free memory slots.
- Forces a write slot if the loader is starved for too long.

---
 rtl/framebuffer_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/framebuffer_arbiter.sv
// Frame-buffer arbiter: shares one synchronous single-port RAM between the
// latency-critical display fetch path and a buffered image-loader write port.
module framebuffer_arbiter #(
    parameter int unsigned AW       = 13,
    parameter int unsigned DW       = 8,
    parameter int unsigned FB_SIZE  = 6400,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    // display fetch path
    input  logic          disp_req_i,
    input  logic [AW-1:0] disp_addr_i,
    output logic          disp_valid_o,
    output logic [DW-1:0] disp_data_o,
    output logic          disp_miss_o,
    // loader write port
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_err_o,
    // RAM side
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
    } slot_e;

    slot_e         slot_q, slot_d;

    logic [AW-1:0] fifo_addr_q [DEPTH];
    logic [DW-1:0] fifo_data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [SW-1:0] starve_q, starve_d;

    logic [AW-1:0] mem_addr_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_wdata_q;

    logic          rd_s2_q;
    logic          disp_valid_q;
    logic [DW-1:0] disp_data_q;
    logic          disp_miss_q, miss_d;
    logic          wr_err_q;

    logic          fifo_empty, fifo_full;
    logic          accept, in_range, push, pop, force_wr;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign wr_ready_o = !fifo_full;

    // Out-of-range writes are still accepted (handshake completes) but never stored.
    assign accept   = wr_valid_i && !fifo_full;
    assign in_range = (32'(wr_addr_i) < FB_SIZE);
    assign push     = accept && in_range;
    assign force_wr = !fifo_empty && (starve_q == SW'(MAX_WAIT));
    assign pop      = (slot_d == StWrite);

    // Slot decision: starved write beats display, display beats normal drain.
    always_comb begin
        slot_d = StIdle;
        miss_d = 1'b0;
        if (force_wr) begin
            slot_d = StWrite;
            miss_d = disp_req_i;
        end else if (disp_req_i) begin
            slot_d = StRead;
        end else if (!fifo_empty) begin
            slot_d = StWrite;
        end
    end

    // Starve counter: counts cycles a pending write is passed over, saturating.
    always_comb begin
        starve_d = '0;
        if (!fifo_empty && !pop) begin
            starve_d = (starve_q == SW'(MAX_WAIT)) ? starve_q : starve_q + SW'(1);
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr_i;
            fifo_data_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // FIFO pointers, occupancy, starve counter and slot state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            slot_q   <= StIdle;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            starve_q <= starve_d;
            slot_q   <= slot_d;
        end
    end

    // RAM command registers; an idle slot keeps the last address on the bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            unique case (slot_d)
                StRead: begin
                    mem_addr_q <= disp_addr_i;
                    mem_we_q   <= 1'b0;
                end
                StWrite: begin
                    mem_addr_q  <= fifo_addr_q[rd_ptr_q];
                    mem_wdata_q <= fifo_data_q[rd_ptr_q];
                    mem_we_q    <= 1'b1;
                end
                default: begin
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    // Display return path: RAM data lands one cycle after the read slot, then is registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_s2_q      <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            disp_miss_q  <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            rd_s2_q      <= (slot_q == StRead);
            disp_valid_q <= rd_s2_q;
            if (rd_s2_q) disp_data_q <= mem_rdata_i;
            disp_miss_q  <= miss_d;
            if (accept && !in_range) wr_err_q <= 1'b1;
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign disp_valid_o = disp_valid_q;
    assign disp_data_o  = disp_data_q;
    assign disp_miss_o  = disp_miss_q;
    assign wr_err_o     = wr_err_q;

endmodule
